// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: one-hot state encoding and the
// circular first-set search used by the round-robin selector.
package uart_tx_arb_pkg;

    localparam int ST_W         = 5;
    localparam int MAX_REQ      = 8;

    localparam int IDLE_B       = 0;
    localparam int LOAD_B       = 1;
    localparam int START_B      = 2;
    localparam int WAIT_BUSY_B  = 3;
    localparam int WAIT_DONE_B  = 4;

    localparam logic [ST_W-1:0] IDLE      = 5'b00001;
    localparam logic [ST_W-1:0] LOAD      = 5'b00010;
    localparam logic [ST_W-1:0] START     = 5'b00100;
    localparam logic [ST_W-1:0] WAIT_BUSY = 5'b01000;
    localparam logic [ST_W-1:0] WAIT_DONE = 5'b10000;

    // Returns {found, index} of the first set bit at or after start, wrapping at n.
    function automatic logic [3:0] rr_first_set(input logic [7:0] vec,
                                                input logic [2:0] start,
                                                input int n);
        logic [3:0] res;
        int k;
        res = 4'b0000;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = int'(start) + i;
            if (k >= n) k = k - n;
            if (i < n && !res[3] && vec[k[2:0]]) res = {1'b1, k[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [7:0] vec;
    logic [2:0] start;
    logic [3:0] res;

    always_comb begin
        vec        = '0;
        vec[N-1:0] = req;
        start      = 3'(ptr);
        res        = rr_first_set(vec, start, N);
        valid      = res[3];
        idx        = PTR_W'(res[2:0]);
        pick       = '0;
        if (res[3]) pick[idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N byte-stream requesters,
// with optional locked bursts of up to BURST_MAX bytes per grant.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int BURST_MAX = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [8*N-1:0] data,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic           busy,
    input  logic           tx_ready,
    output logic           tx_start_tick,
    output logic [7:0]     tx_d
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    logic [ST_W-1:0]  state_reg;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_next;
    logic [PTR_W-1:0] pick_idx;
    logic [N-1:0]     pick;
    logic             pick_valid;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W:0]   burst_inc;
    logic             keep_grant;

    rr_pick #(.N(N), .PTR_W(PTR_W)) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // The releasing requester drops to lowest priority by moving the pointer past it.
    always_comb begin
        burst_inc  = {1'b0, burst_cnt} + (CNT_W+1)'(1);
        owner_next = (owner == PTR_W'(N-1)) ? '0 : owner + PTR_W'(1);
        keep_grant = lock[owner] && req[owner] &&
                     (burst_inc < (CNT_W+1)'(BURST_MAX));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            grant         <= '0;
            ack           <= '0;
            tx_start_tick <= 1'b0;
            tx_d          <= '0;
            busy          <= 1'b0;
            ptr           <= '0;
            owner         <= '0;
            burst_cnt     <= '0;
        end else begin
            ack           <= '0;
            tx_start_tick <= 1'b0;
            case (1'b1)
                state_reg[IDLE_B]: begin
                    if (pick_valid) begin
                        grant     <= pick;
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                state_reg[LOAD_B]: begin
                    if (!req[owner]) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        ptr       <= owner_next;
                        state_reg <= IDLE;
                    end else if (tx_ready) begin
                        tx_start_tick <= 1'b1;
                        ack           <= grant;
                        tx_d          <= data[8*owner +: 8];
                        state_reg     <= START;
                    end
                end
                state_reg[START_B]: begin
                    state_reg <= WAIT_BUSY;
                end
                state_reg[WAIT_BUSY_B]: begin
                    if (!tx_ready) state_reg <= WAIT_DONE;
                end
                // Frame complete: either continue the locked burst or hand the grant on.
                state_reg[WAIT_DONE_B]: begin
                    if (tx_ready) begin
                        burst_cnt <= burst_inc[CNT_W-1:0];
                        if (keep_grant) begin
                            state_reg <= LOAD;
                        end else begin
                            grant     <= '0;
                            busy      <= 1'b0;
                            ptr       <= owner_next;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    grant     <= '0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
